rgb2raw_mosaic: RTL and testbench

// - Re-mosaics an RGB pixel stream into a sensor-style 12-bit Bayer raw stream with X/Y counters.
// - Output matches the sensor capture interface (raw data, X/Y counters and a data-valid strobe).
// - Sits in front of the Bayer-to-RGB/gray pipeline in place of the camera, for loopback and regression.
// - Inserts line and frame blanking so downstream line buffers see sensor-like timing.

---
 rtl/rgb2raw_mosaic.sv | 165 ++++++++++++++++
 tb/tb_rgb2raw_mosaic.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2raw_mosaic.sv
// rgb2raw_mosaic
//   Re-mosaics an RGB pixel stream into a 12-bit Bayer raw stream with X/Y
//   counters and sensor-like line/frame blanking. It stands in for a camera
//   capture interface in loopback and regression setups.
//
//   Bayer phase {row[0],col[0]}: 00 G, 01 R, 10 B, 11 G.
//
// Optional feature macro: RGB2RAW_TPG_EN
//   Adds iTPG. This input is latched on the first ACTIVE cycle of each frame,
//   which is either the cycle after reset release or the cycle after VBLANK
//   exit. While the latch is 1, the input RGB is ignored. Pixels are then
//   accepted whenever oReady is high, and oDATA = col + row.
//
// Ports
//   iCLK, iRST              clock, asynchronous active-low reset
//   iRed/iGreen/iBlue [12]  input pixel components
//   iValid                  input pixel valid
//   iTPG                    test-pattern enable (only with RGB2RAW_TPG_EN)
//   oReady                  pixel accepted this cycle if iValid (ACTIVE only)
//   oDATA [12]              Bayer raw sample, one cycle after accept
//   oDVAL                   oDATA/oX_Cont/oY_Cont valid
//   oX_Cont/oY_Cont [11]    column/row of oDATA
//   oSOF/oEOF               pulse with pixel (0,0) / (IMG_W-1,IMG_H-1)
module rgb2raw_mosaic #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int H_BLANK = 16,
  parameter int V_BLANK = 32
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iRed,
  input  logic [11:0] iGreen,
  input  logic [11:0] iBlue,
  input  logic        iValid,
`ifdef RGB2RAW_TPG_EN
  input  logic        iTPG,
`endif
  output logic        oReady,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oSOF,
  output logic        oEOF
);

  typedef enum logic [1:0] {ACTIVE, HBLANK, VBLANK} state_t;

  localparam logic [10:0] LAST_COL = 11'(IMG_W - 1);
  localparam logic [10:0] LAST_ROW = 11'(IMG_H - 1);
  localparam logic [31:0] HB_LAST  = 32'(H_BLANK - 1);
  localparam logic [31:0] VB_LAST  = 32'(V_BLANK - 1);

  state_t      state, state_nx;
  logic [10:0] col, col_nx, row, row_nx;
  logic [31:0] bcnt, bcnt_nx;
  logic        accept;
  logic [11:0] bayer, pix;

  assign oReady = (state == ACTIVE);

  always_comb begin
    case ({row[0], col[0]})
      2'b01:   bayer = iRed;
      2'b10:   bayer = iBlue;
      default: bayer = iGreen;
    endcase
  end

`ifdef RGB2RAW_TPG_EN
  logic frame_entry, tpg_lat, tpg_eff;

  // On the entry cycle, use iTPG directly so the first pixel already
  // follows the newly sampled mode.
  assign tpg_eff = frame_entry ? iTPG : tpg_lat;
  assign accept  = oReady & (iValid | tpg_eff);
  assign pix     = tpg_eff ? ({1'b0, col} + {1'b0, row}) : bayer;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      frame_entry <= 1'b1;
      tpg_lat     <= 1'b0;
    end else begin
      frame_entry <= (state == VBLANK) && (bcnt == VB_LAST);
      if (frame_entry) tpg_lat <= iTPG;
    end
  end
`else
  assign accept = oReady & iValid;
  assign pix    = bayer;
`endif

  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    bcnt_nx  = bcnt;
    case (state)
      ACTIVE: begin
        if (accept) begin
          if (col == LAST_COL) begin
            col_nx  = '0;
            bcnt_nx = '0;
            if (row == LAST_ROW) begin
              row_nx   = '0;
              state_nx = VBLANK;
            end else begin
              row_nx   = row + 11'd1;
              state_nx = HBLANK;
            end
          end else begin
            col_nx = col + 11'd1;
          end
        end
      end
      HBLANK: begin
        if (bcnt == HB_LAST) begin
          state_nx = ACTIVE;
          bcnt_nx  = '0;
        end else begin
          bcnt_nx = bcnt + 32'd1;
        end
      end
      VBLANK: begin
        if (bcnt == VB_LAST) begin
          state_nx = ACTIVE;
          bcnt_nx  = '0;
        end else begin
          bcnt_nx = bcnt + 32'd1;
        end
      end
      default: state_nx = ACTIVE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state   <= ACTIVE;
      col     <= '0;
      row     <= '0;
      bcnt    <= '0;
      oDATA   <= '0;
      oDVAL   <= 1'b0;
      oX_Cont <= '0;
      oY_Cont <= '0;
      oSOF    <= 1'b0;
      oEOF    <= 1'b0;
    end else begin
      state <= state_nx;
      col   <= col_nx;
      row   <= row_nx;
      bcnt  <= bcnt_nx;
      oDVAL <= accept;
      oSOF  <= accept && (col == '0) && (row == '0);
      oEOF  <= accept && (col == LAST_COL) && (row == LAST_ROW);
      if (accept) begin
        oDATA   <= pix;
        oX_Cont <= col;
        oY_Cont <= row;
      end
    end
  end

endmodule

// File: tb/tb_rgb2raw_mosaic.sv
module tb_rgb2raw_mosaic;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int VB = 3;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [11:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic        iValid = 1'b0;
  logic        iTPG = 1'b0;
  logic        oReady, oDVAL, oSOF, oEOF;
  logic [11:0] oDATA;
  logic [10:0] oX_Cont, oY_Cont;

  rgb2raw_mosaic #(.IMG_W(W), .IMG_H(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .iCLK(iCLK), .iRST(iRST), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iValid(iValid),
`ifdef RGB2RAW_TPG_EN
    .iTPG(iTPG),
`endif
    .oReady(oReady), .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont),
    .oY_Cont(oY_Cont), .oSOF(oSOF), .oEOF(oEOF)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int failures = 0;

  // Reference model: pixel index within frame plus remaining blank cycles.
  int          m_pix, m_blank, frames_done;
  logic        m_vb, m_entry, m_tpg;
  logic        exp_ready, obs_ready, exp_dval, exp_sof, exp_eof;
  logic [11:0] exp_data;
  logic [10:0] exp_x, exp_y;

  task automatic model_reset();
    m_pix = 0; m_blank = 0; m_vb = 0; m_entry = 1; m_tpg = 0;
    exp_dval = 0; exp_sof = 0; exp_eof = 0; exp_data = '0; exp_x = '0; exp_y = '0;
  endtask

  task automatic model_clock(input logic v, input logic [11:0] r, g, b, input logic tpg);
    int x, y;
    logic acc;
    if (m_blank == 0 && m_entry) begin
      m_tpg = tpg;
      m_entry = 0;
    end
    acc = (m_blank == 0) && (v || m_tpg);
    exp_sof = 0; exp_eof = 0; exp_dval = acc;
    if (acc) begin
      x = m_pix % W;
      y = m_pix / W;
      exp_x = 11'(x);
      exp_y = 11'(y);
      exp_sof = (m_pix == 0);
      exp_eof = (m_pix == W * H - 1);
      if (m_tpg) exp_data = 12'(x + y);
      else if (y % 2 == 0) exp_data = (x % 2 == 0) ? g : r;
      else exp_data = (x % 2 == 0) ? b : g;
      m_pix++;
      if (x == W - 1) begin
        if (y == H - 1) begin
          m_pix = 0; m_blank = VB; m_vb = 1; frames_done++;
        end else begin
          m_blank = HB;
        end
      end
    end else if (m_blank > 0) begin
      m_blank--;
      if (m_blank == 0 && m_vb) begin
        m_vb = 0;
        m_entry = 1;
      end
    end
  endtask

  // One clock of stimulus; returns at posedge+1 with model expectations updated.
  task automatic tick(input logic v, input logic [11:0] r, g, b, input logic tpg);
    iValid = v; iRed = r; iGreen = g; iBlue = b; iTPG = tpg;
    #4;
    obs_ready = oReady;
    exp_ready = (m_blank == 0);
    model_clock(v, r, g, b, tpg);
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST = 1'b0; iValid = 1'b0;
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    model_reset();
    frames_done = 0;
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    #7;
    checks++;
    if ({oReady, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF} !== {1'b1, 1'b0, 12'h0, 11'd0, 11'd0, 1'b0, 1'b0})
      begin failures++; $display("FAIL reset_state got rdy=%b dv=%b d=%h x=%0d y=%0d s=%b e=%b exp rdy=1 others 0",
        oReady, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF); end
    do_reset();
  endtask

  task automatic test_fixed_colors();
    logic [11:0] seq [$];
    logic [11:0] want [8] = '{12'h222, 12'h111, 12'h222, 12'h111, 12'h333, 12'h222, 12'h333, 12'h222};
    do_reset();
    for (int c = 0; c < 28; c++) begin
      tick(1'b1, 12'h111, 12'h222, 12'h333, 1'b0);
      if (oDVAL) seq.push_back(oDATA);
      checks++;
      if ({obs_ready, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF} !== {exp_ready, exp_dval, exp_data, exp_x, exp_y, exp_sof, exp_eof})
        begin failures++; $display("FAIL fixed cyc=%0d got rdy=%b dv=%b d=%h x=%0d y=%0d s=%b e=%b exp rdy=%b dv=%b d=%h x=%0d y=%0d s=%b e=%b",
          c, obs_ready, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF, exp_ready, exp_dval, exp_data, exp_x, exp_y, exp_sof, exp_eof); end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= seq.size()) begin failures++; $display("FAIL fixed_seq[%0d] got none exp %h", i, want[i]); end
      else if (seq[i] !== want[i]) begin failures++; $display("FAIL fixed_seq[%0d] got %h exp %h", i, seq[i], want[i]); end
    end
  endtask

  task automatic test_toggle();
    int xs [$];
    do_reset();
    for (int c = 0; c < 16; c++) begin
      tick(c % 2 == 0, 12'(c), 12'(c + 16), 12'(c + 32), 1'b0);
      if (oDVAL) xs.push_back(int'(oX_Cont));
      checks++;
      if ({obs_ready, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF} !== {exp_ready, exp_dval, exp_data, exp_x, exp_y, exp_sof, exp_eof})
        begin failures++; $display("FAIL toggle cyc=%0d got dv=%b d=%h x=%0d y=%0d exp dv=%b d=%h x=%0d y=%0d",
          c, oDVAL, oDATA, oX_Cont, oY_Cont, exp_dval, exp_data, exp_x, exp_y); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= xs.size() || xs[i] != i) begin failures++;
        $display("FAIL toggle_col[%0d] got %0d exp %0d", i, (i < xs.size()) ? xs[i] : -1, i); end
    end
  endtask

  task automatic test_random_frames();
    int sofs = 0, eofs = 0;
    do_reset();
    for (int c = 0; c < 600 && frames_done < 3; c++) begin
      tick(1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
           12'($urandom_range(0, 4095)), 1'b0);
      sofs += int'(oSOF);
      eofs += int'(oEOF);
      checks++;
      if ({obs_ready, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF} !== {exp_ready, exp_dval, exp_data, exp_x, exp_y, exp_sof, exp_eof})
        begin failures++; $display("FAIL random cyc=%0d got rdy=%b dv=%b d=%h x=%0d y=%0d s=%b e=%b exp rdy=%b dv=%b d=%h x=%0d y=%0d s=%b e=%b",
          c, obs_ready, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF, exp_ready, exp_dval, exp_data, exp_x, exp_y, exp_sof, exp_eof); end
    end
    checks++;
    if (frames_done != 3 || sofs != 3 || eofs != 3) begin failures++;
      $display("FAIL frame_pulses got sof=%0d eof=%0d frames=%0d exp 3/3/3", sofs, eofs, frames_done); end
  endtask

  task automatic test_mid_reset();
    int c = 0;
    do_reset();
    do begin
      tick(1'b1, 12'h0AA, 12'h0BB, 12'h0CC, 1'b0);
      c++;
    end while (!(exp_dval && exp_x == 11'd2 && exp_y == 11'd0) && c < 20);
    iRST = 1'b0;
    #1;
    checks++;
    if ({oReady, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF} !== {1'b1, 1'b0, 12'h0, 11'd0, 11'd0, 1'b0, 1'b0})
      begin failures++; $display("FAIL mid_reset got rdy=%b dv=%b d=%h x=%0d y=%0d s=%b e=%b exp rdy=1 others 0 (after %0d cycles)",
        oReady, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF, c); end
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    model_reset();
    tick(1'b1, 12'h0AA, 12'h0BB, 12'h0CC, 1'b0);
    checks++;
    if ({obs_ready, oDVAL, oX_Cont, oY_Cont, oSOF, oDATA} !== {1'b1, 1'b1, 11'd0, 11'd0, 1'b1, 12'h0BB})
      begin failures++; $display("FAIL after_reset got rdy=%b dv=%b x=%0d y=%0d s=%b d=%h exp rdy=1 dv=1 x=0 y=0 s=1 d=0bb",
        obs_ready, oDVAL, oX_Cont, oY_Cont, oSOF, oDATA); end
  endtask

`ifdef RGB2RAW_TPG_EN
  task automatic test_tpg();
    logic t;
    int seen = 0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      // Frame 0 and 1 start with iTPG=1; iTPG drops mid-frame 1, and frame 2
      // then starts with iTPG=0 and iValid=0, so it must stall.
      t = (frames_done == 0) || (frames_done == 1 && c < 16);
      tick(1'b0, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), t);
      if (oDVAL && oX_Cont == 11'd3 && oY_Cont == 11'd1) begin
        seen++;
        checks++;
        if (oDATA !== 12'h004) begin failures++; $display("FAIL tpg_corner got %h exp 004", oDATA); end
      end
      checks++;
      if ({obs_ready, oDVAL, oDATA, oX_Cont, oY_Cont, oSOF, oEOF} !== {exp_ready, exp_dval, exp_data, exp_x, exp_y, exp_sof, exp_eof})
        begin failures++; $display("FAIL tpg cyc=%0d got rdy=%b dv=%b d=%h x=%0d y=%0d exp rdy=%b dv=%b d=%h x=%0d y=%0d",
          c, obs_ready, oDVAL, oDATA, oX_Cont, oY_Cont, exp_ready, exp_dval, exp_data, exp_x, exp_y); end
    end
    checks++;
    if (seen != 2) begin failures++; $display("FAIL tpg_frames got %0d exp 2", seen); end
  endtask
`endif

  initial begin
    model_reset();
    frames_done = 0;
    test_reset();
    test_fixed_colors();
    test_toggle();
    test_random_frames();
    test_mid_reset();
`ifdef RGB2RAW_TPG_EN
    test_tpg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
